// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, crossbar selects, arbiter states.
package noc_pkg;

  localparam int unsigned NPORTS = 5;

  typedef enum logic [2:0] {
    P_N = 3'd0,
    P_E = 3'd1,
    P_W = 3'd2,
    P_S = 3'd3,
    P_L = 3'd4
  } port_e;

  localparam logic [4:0] XSEL_N = 5'b00001;
  localparam logic [4:0] XSEL_E = 5'b00010;
  localparam logic [4:0] XSEL_W = 5'b00100;
  localparam logic [4:0] XSEL_S = 5'b01000;
  localparam logic [4:0] XSEL_L = 5'b10000;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // One-hot crossbar select for a port index; out-of-range indices select nothing.
  function automatic logic [4:0] port_onehot(input logic [2:0] idx);
    case (idx)
      P_N:     return XSEL_N;
      P_E:     return XSEL_E;
      P_W:     return XSEL_W;
      P_S:     return XSEL_S;
      P_L:     return XSEL_L;
      default: return '0;
    endcase
  endfunction

  // Next port in cyclic N,E,W,S,L order.
  function automatic logic [2:0] port_next(input logic [2:0] idx);
    return (idx >= P_L) ? P_N : idx + 3'd1;
  endfunction

endpackage

// File: rtl/credit_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found searching cyclically from ptr.
module rr_pick
  import noc_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic       found,
  output logic [2:0] idx
);

  logic [2:0] cand;

  // Walk the five ports starting at ptr and latch the first one requesting.
  always_comb begin
    found = 1'b0;
    idx   = P_N;
    cand  = ptr;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (!found && (cand <= P_L) && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = port_next(cand);
    end
  end

endmodule

// File: rtl/credit_arbiter.sv
// Output-port allocator: packet-locked round-robin grant with downstream credit tracking.
module credit_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    req,
  input  logic [4:0]    tail,
  input  logic          credit_in,
  output logic [4:0]    grant,
  output logic [4:0]    Xbar_sel,
  output logic          valid_out,
  output logic [CW-1:0] credit_cnt,
  output logic          busy,
  output logic          credit_err
);

  arb_state_e state, state_nxt;
  logic [2:0] owner, owner_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic       win_found;
  logic [2:0] win_idx;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .found (win_found),
    .idx   (win_idx)
  );

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= P_N;
      ptr   <= P_L;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state and output decode: lock on arbitration, release after the granted tail flit.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    grant     = '0;
    Xbar_sel  = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          owner_nxt = win_idx;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        busy     = 1'b1;
        Xbar_sel = port_onehot(owner);
        if (req[owner] && (credit_cnt != '0)) begin
          grant = port_onehot(owner);
          if (tail[owner]) begin
            state_nxt = IDLE;
            ptr_nxt   = port_next(owner);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign valid_out = |grant;

  // Credit counter: spend on a transferred flit, refill on credit_in; overflow returns are flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CW'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      case ({valid_out, credit_in})
        2'b10:   credit_cnt <= credit_cnt - CW'(1);
        2'b01: begin
          if (credit_cnt == CW'(CREDITS)) credit_err <= 1'b1;
          else                            credit_cnt <= credit_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/credit_arbiter.md
# credit_arbiter

Output-port allocator for the 5-port mesh router: shares one output link among the N, E, W, S and L input FIFOs. It holds a grant for a whole packet (head to tail flit), uses round-robin fairness between packets, and spends and returns downstream buffer credits. This block replaces the RTS/DCTS handshake on credit-based links. It drives the crossbar select for its output port and pops the winning input FIFO once per transferred flit.

## Interface
Parameters:
- CREDITS, 4: downstream input-buffer depth in flits; range 1..15.
- CW, $clog2(CREDITS+1): credit counter width; derived, not overridden.

Ports (bit index for every 5-bit vector: 0=N, 1=E, 2=W, 3=S, 4=L):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  5  input FIFO i is non-empty; its head flit targets this output.
- tail  in  5  head flit of FIFO i is a tail flit; valid only while req[i]=1.
- credit_in  in  1  downstream freed one buffer slot this cycle.
- grant  out  5  one-hot or zero; pop FIFO i this cycle; combinational from registered state, req and credit count.
- Xbar_sel  out  5  one-hot crossbar select: N=00001, E=00010, W=00100, S=01000, L=10000. Value is 00000 when idle.
- valid_out  out  1  a flit crosses the link this cycle; equals OR of grant.
- credit_cnt  out  CW  available downstream credits, registered.
- busy  out  1  the port is locked to a packet.
- credit_err  out  1  sticky flag: a credit was returned while credit_cnt==CREDITS.

## Operation
- States: IDLE and LOCKED. Registers: owner (3-bit port index), ptr (round-robin start index), credit_cnt, credit_err.
- IDLE:
  - grant=0, Xbar_sel=00000, busy=0.
  - If req≠0, pick the first set bit searching cyclically from ptr in the order N,E,W,S,L.
  - On the next edge: owner=winner, move to LOCKED.
  - Arbitration does not depend on credits.
- LOCKED:
  - Xbar_sel=onehot(owner), busy=1.
  - grant[owner]=req[owner] && credit_cnt≠0. All other grant bits are 0.
  - A granted flit with tail[owner]=1 moves the block to IDLE and sets ptr=(owner+1) mod 5.
  - If req[owner] drops mid-packet, the block stays LOCKED with no grant (bubble). Other requesters never preempt the owner.
- Credit counter:
  - credit_cnt_next = credit_cnt − valid_out + credit_in.
  - A spend and a return in the same cycle leave the count unchanged.
  - A return at credit_cnt==CREDITS with no spend is dropped (count holds) and sets credit_err.
  - A spend at 0 is impossible by construction.
- Single-flit packet (head is also tail): one grant cycle, then IDLE.
- A packet may start while credit_cnt=0. It locks and waits for credits.

## Timing
- Reset values: state=IDLE, owner=N, ptr=L (first search order L,N,E,W,S after reset), credit_cnt=CREDITS, credit_err=0. Outputs: grant=00000, Xbar_sel=00000, valid_out=0, busy=0.
- Reset asserted mid-packet: on the next edge the block returns to IDLE, credits are refilled to CREDITS, and the packet is abandoned. Upstream flush is not this block's job.
- Latency: req rises at cycle t in IDLE → LOCKED at t+1 → first grant at t+1, if a credit is available.
- Back-to-back packets: the tail is granted at cycle t → IDLE at t+1 → next owner LOCKED at t+2. One bubble cycle per packet boundary.
- Steady state: one flit per cycle while req[owner]=1 and credit_cnt≥1.
- A credit returned at cycle t is usable at t+1.
- grant is valid in the same cycle as the inputs. FIFO pop and downstream write occur on the edge that ends that cycle.

## Structure
- Shared package noc_pkg:
  - NPORTS=5.
  - Port index enum P_N=0, P_E=1, P_W=2, P_S=3, P_L=4.
  - Xbar one-hot constants XSEL_N … XSEL_L.
  - Arbiter state enum {IDLE, LOCKED}.
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: req[4:0] and ptr[2:0].
  - Outputs: found and idx[2:0].
  - Reusable by the input-side VC allocator.
- The top level holds the FSM, the credit counter and the output decode.

## Test plan
- Reset, then req=00010 (E) and tail=00010 held with CREDITS=4 → LOCKED next cycle, Xbar_sel=00010, grant=00010 for one cycle, IDLE the cycle after, ptr=W.
- After reset, req=11111 and every packet 2 flits long → owners granted in order L,N,E,W,S,L. Each packet gets two grant cycles, with one idle bubble between packets.
- Credits: CREDITS=2, no credit_in, 4-flit packet from N → two grants, then credit_cnt=0 and grant=0. Pulse credit_in once → exactly one more grant on the following cycle.
- Simultaneous spend and return at credit_cnt=1 → credit_cnt stays 1. credit_in at credit_cnt=CREDITS in IDLE → count stays CREDITS, credit_err=1 and sticky until rst.
- Mid-packet: req[owner] drops for 3 cycles while S also requests → busy=1, grant=0, Xbar_sel unchanged. The owner resumes; S is served only after the owner's tail flit.
- rst during LOCKED with credit_cnt=1 → next cycle state=IDLE, grant=0, Xbar_sel=00000, credit_cnt=CREDITS, ptr=L.
